sccb_bus_monitor: RTL and testbench
===================================

Name: sccb_bus_monitor

Overview:
- Passive SCCB/I2C bus sniffer that generalises the single 32-bit SCL-edge shift capture into a transaction-aware monitor.
- Synchronises and glitch-filters SCL/SDA, detects START/STOP/repeated-START, and assembles 9-bit frames into per-transaction records.
- Buffers records in a FWFT FIFO with a valid/ready interface for an ILA or a PS-readable register block.
- Sits beside the camera IIC pads in the top level. It observes only and never drives the bus.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (min 2).
- GLITCH_CYCLES, 3, consecutive equal synchronised samples required before a filtered level changes (min 1).
- MAX_BYTES, 4, bytes stored per record.
- FIFO_DEPTH, 8, record FIFO entries (power of 2, min 2).
- SHIFT_W, 32, width of the free-running raw bit shift register.

Ports:
- clk  in  1  system clock (FCLK domain).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  monitor enable.
- scl_in  in  1  raw SCL pad level.
- sda_in  in  1  raw SDA pad level.
- rec_valid  out  1  FIFO head record valid.
- rec_ready  in  1  consumer accepts head record.
- rec_data  out  8*MAX_BYTES  bytes; byte k in bits [8k+7:8k], first byte at k=0.
- rec_nbytes  out  $clog2(MAX_BYTES+1)  complete bytes stored.
- rec_nack  out  MAX_BYTES  bit k = sampled 9th bit of byte k (1 = NACK).
- rec_trunc  out  1  more than MAX_BYTES complete bytes seen.
- rec_partial  out  1  transaction ended mid-byte.
- rec_restart  out  1  record closed by repeated START (0 = STOP).
- bus_busy  out  1  high between START and STOP.
- shift_out  out  SHIFT_W  every sampled bit, shifted in LSB-first at the SCL rise.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  stored records.
- drop_cnt  out  16  records lost to FIFO full; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0, FSM IDLE, filtered SCL/SDA = 1, FIFO empty, drop_cnt 0.
- Filtering:
  - Each line passes SYNC_STAGES flops, then a counter.
  - The filtered level flips only after GLITCH_CYCLES consecutive samples differ from it.
  - Pad-to-filtered latency is SYNC_STAGES+GLITCH_CYCLES clk cycles.
- Event detection (filtered, registered previous values):
  - START = SDA 1->0 with SCL high in both the previous and current cycle.
  - STOP = SDA 0->1 under the same SCL condition.
  - BIT = SCL 0->1; sample the current filtered SDA.
  - If SCL and SDA change in the same cycle, only the SCL edge is processed.
- FSM:
  - IDLE: START -> ACTIVE; clear bit_cnt, byte_cnt, record fields.
  - ACTIVE:
    - BIT: bits 0-7 shift into the current byte MSB-first.
    - Bit 8 stores rec_nack[byte_cnt], increments byte_cnt, resets bit_cnt.
    - Bytes beyond MAX_BYTES set trunc and are not stored; byte_cnt saturates at MAX_BYTES.
    - STOP -> EMIT with restart=0.
    - START -> EMIT with restart=1.
  - EMIT (one cycle):
    - partial = (bit_cnt != 0).
    - Record is written if byte_cnt != 0 or partial. An empty START/STOP pair is discarded silently.
    - FIFO full: record dropped, drop_cnt +1.
    - Next state: ACTIVE with cleared fields if restart, else IDLE.
- bus_busy: 1 from the START cycle through the STOP cycle, including across repeated STARTs.
- rec_valid asserts the cycle after EMIT when the FIFO was empty (FWFT).
- Pop on rec_valid & rec_ready. A simultaneous push and pop at full is allowed and drops nothing.
- shift_out updates on every BIT event in any state, including IDLE.
- enable = 0: FSM forced to IDLE next cycle and the in-progress record discarded. FIFO, drop_cnt and shift_out are retained. A bus already mid-transaction is ignored until the next START.
- rst mid-transaction: immediate return to reset state; FIFO contents lost.

Test Plan:
- Write 0x42,0x0A,0x5C with ACKs then STOP (MAX_BYTES=4) -> one record: rec_nbytes=3, rec_data[23:0]=0x5C0A42, rec_nack=0, trunc/partial/restart=0, bus_busy low after STOP.
- START, 0x43 ACK, repeated START, 0x43, data 0x9D NACK, STOP -> two records:
  - first: nbytes=1, restart=1.
  - second: nbytes=2, data[15:0]=0x9D43, rec_nack=4'b0010, restart=0.
  - bus_busy high throughout.
- Six ACKed bytes 0x01..0x06 then STOP -> nbytes=4, data=0x04030201, trunc=1.
- START, 5 bits, STOP -> partial=1, nbytes=0.
- START then STOP with no bits -> no record, drop_cnt 0.
- SCL low pulses of 2 clk (GLITCH_CYCLES=3) during an active byte -> no bit counted; a 4-clk pulse counts one bit.
- rec_ready=0, 9 one-byte transactions (FIFO_DEPTH=8) -> fifo_level=8, drop_cnt=1. Then draining 8 pops shows the first 8 bytes in order.
- rst asserted mid-byte then released, followed by a full 1-byte write -> single clean record, no partial.

Source files
------------

// File: rtl/sccb_bus_monitor_if.sv
// ---------------------------------------------------------------------------
// sccb_bus_monitor_if
// Record stream carried from the SCCB bus monitor to its consumer (an ILA
// probe or a PS-readable register block). The head of the record FIFO is
// presented first-word-fall-through; a record leaves on rec_valid & rec_ready.
//
// Signals:
//   rec_valid    head record valid
//   rec_ready    consumer accepts the head record
//   rec_data     captured bytes, byte k in [8k+7:8k], first byte at k=0
//   rec_nbytes   number of complete bytes stored
//   rec_nack     bit k = 9th (acknowledge) bit of byte k, 1 = NACK
//   rec_trunc    more complete bytes were seen than could be stored
//   rec_partial  transaction ended part-way through a byte
//   rec_restart  record closed by a repeated START (0 = closed by STOP)
//
// Modports: master = monitor side, slave = consumer side.
// ---------------------------------------------------------------------------
interface sccb_bus_monitor_if #(
    parameter int MAX_BYTES = 4
);
    localparam int NBW = $clog2(MAX_BYTES + 1);

    logic                   rec_valid;
    logic                   rec_ready;
    logic [8*MAX_BYTES-1:0] rec_data;
    logic [NBW-1:0]         rec_nbytes;
    logic [MAX_BYTES-1:0]   rec_nack;
    logic                   rec_trunc;
    logic                   rec_partial;
    logic                   rec_restart;

    modport master (
        output rec_valid, rec_data, rec_nbytes, rec_nack,
               rec_trunc, rec_partial, rec_restart,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_data, rec_nbytes, rec_nack,
               rec_trunc, rec_partial, rec_restart,
        output rec_ready
    );
endinterface

// File: rtl/sccb_bus_monitor.sv
// ---------------------------------------------------------------------------
// sccb_bus_monitor
// Passive SCCB/I2C sniffer. SCL/SDA are synchronised and glitch-filtered,
// START/STOP/repeated-START and clock edges are detected on the filtered
// levels, and each transaction is assembled into a record that is pushed into
// a first-word-fall-through FIFO. The bus is only observed, never driven.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   enable       monitor enable; low forces the FSM idle and drops the
//                record being assembled
//   scl_in/sda_in raw pad levels
//   rec          record stream (master modport of sccb_bus_monitor_if)
//   bus_busy     high between START and STOP
//   shift_out    every sampled bit, shifted in at bit 0 on each SCL rise
//   fifo_level   records currently stored
//   drop_cnt     records lost because the FIFO was full (saturating)
// ---------------------------------------------------------------------------
module sccb_bus_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 3,
    parameter int MAX_BYTES     = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int SHIFT_W       = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             scl_in,
    input  logic                             sda_in,
    sccb_bus_monitor_if.master               rec,
    output logic                             bus_busy,
    output logic [SHIFT_W-1:0]               shift_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      drop_cnt
);
    localparam int NBW = $clog2(MAX_BYTES + 1);
    localparam int GCW = $clog2(GLITCH_CYCLES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int RW  = 8*MAX_BYTES + NBW + MAX_BYTES + 3;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EMIT} state_t;

    // Synchroniser chains (index 0 = SCL, 1 = SDA after the chain)
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic [1:0]             w_sync_out;
    logic [1:0]             r_filt, r_filt_d;
    logic [1:0][GCW-1:0]    r_gcnt;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t r_state, w_next;
    logic   w_clear, w_close, w_emit, w_capture, w_commit;

    logic [3:0]             r_bit_cnt;
    logic [NBW-1:0]         r_byte_cnt;
    logic                   r_pend, r_pend_val;
    logic                   r_trunc, r_restart, r_busy;
    logic [7:0]             r_cur;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [MAX_BYTES-1:0]   r_nack;
    logic [SHIFT_W-1:0]     r_shift;

    logic [RW-1:0]          r_mem [FIFO_DEPTH];
    logic [LW-1:0]          r_wptr, r_rptr;
    logic [LW-1:0]          w_level;
    logic [RW-1:0]          w_rec, w_head;
    logic                   w_partial, w_has, w_full, w_pop, w_push, w_drop;
    logic [15:0]            r_drop;

    // ---- synchronise and filter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign w_sync_out = {r_sda_sync[SYNC_STAGES-1], r_scl_sync[SYNC_STAGES-1]};

    // A filtered level flips only after GLITCH_CYCLES consecutive differing
    // samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_gcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (w_sync_out[i] == r_filt[i]) begin
                    r_gcnt[i] <= '0;
                end else if (r_gcnt[i] == GCW'(GLITCH_CYCLES - 1)) begin
                    r_filt[i] <= w_sync_out[i];
                    r_gcnt[i] <= '0;
                end else begin
                    r_gcnt[i] <= r_gcnt[i] + 1'b1;
                end
            end
        end
    end

    // ---- event detection on filtered levels ----
    // START/STOP need SCL high in both cycles, so a simultaneous SCL/SDA
    // change is only ever seen as an SCL edge.
    assign w_scl_rise = ~r_filt_d[0] &  r_filt[0];
    assign w_scl_fall =  r_filt_d[0] & ~r_filt[0];
    assign w_start    =  r_filt_d[0] &  r_filt[0] &  r_filt_d[1] & ~r_filt[1];
    assign w_stop     =  r_filt_d[0] &  r_filt[0] & ~r_filt_d[1] &  r_filt[1];

    // ---- transaction FSM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        w_close = 1'b0;
        w_emit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_start) begin
                    w_next  = S_ACTIVE;
                    w_clear = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else if (w_stop || w_start) begin
                    w_next  = S_EMIT;
                    w_close = 1'b1;
                end
            end
            S_EMIT: begin
                if (!enable) begin
                    w_next = S_IDLE;
                end else begin
                    w_emit = 1'b1;
                    if (r_restart) begin
                        w_next  = S_ACTIVE;
                        w_clear = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The bit is sampled at the SCL rise but only counted at the following
    // fall. The SCL rise that precedes a STOP or repeated START carries no
    // data; holding it pending lets the STOP/START cancel it.
    assign w_capture = (r_state == S_ACTIVE) & enable & w_scl_rise;
    assign w_commit  = (r_state == S_ACTIVE) & enable & w_scl_fall & r_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_pend     <= 1'b0;
            r_trunc    <= 1'b0;
            r_restart  <= 1'b0;
        end else if (w_clear) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_pend     <= 1'b0;
            r_trunc    <= 1'b0;
            r_restart  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pend <= 1'b1;
            end else if (w_commit) begin
                r_pend <= 1'b0;
                if (r_bit_cnt == 4'd8) begin
                    r_bit_cnt <= '0;
                    if (r_byte_cnt == NBW'(MAX_BYTES)) r_trunc <= 1'b1;
                    else                               r_byte_cnt <= r_byte_cnt + 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_close) begin
                r_restart <= w_start;
                r_pend    <= 1'b0;
            end
        end
    end

    // Record payload; cleared at each START so unused bytes/NACK bits read 0.
    always_ff @(posedge clk) begin
        if (w_capture) r_pend_val <= r_filt[1];
        if (w_clear) begin
            r_data <= '0;
            r_nack <= '0;
        end else if (w_commit) begin
            if (r_bit_cnt != 4'd8) begin
                r_cur <= {r_cur[6:0], r_pend_val};
            end else begin
                for (int k = 0; k < MAX_BYTES; k++) begin
                    if (r_byte_cnt == NBW'(k)) begin
                        r_data[8*k +: 8] <= r_cur;
                        r_nack[k]        <= r_pend_val;
                    end
                end
            end
        end
    end

    // ---- raw shift register and bus busy ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_scl_rise) r_shift <= {r_shift[SHIFT_W-2:0], r_filt[1]};
            if (enable && w_start)       r_busy <= 1'b1;
            else if (w_stop || !enable)  r_busy <= 1'b0;
        end
    end

    // ---- record FIFO ----
    assign w_partial = (r_bit_cnt != 4'd0);
    assign w_has     = (r_byte_cnt != '0) | w_partial;
    assign w_level   = r_wptr - r_rptr;
    assign w_full    = (w_level == LW'(FIFO_DEPTH));
    assign w_pop     = rec.rec_valid & rec.rec_ready;
    assign w_push    = w_emit & w_has & (~w_full | w_pop);
    assign w_drop    = w_emit & w_has & w_full & ~w_pop;
    assign w_rec     = {r_restart, w_partial, r_trunc, r_nack, r_byte_cnt, r_data};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
        end
    end

    // Fields read zero while the FIFO is empty.
    assign rec.rec_valid = (w_level != '0);
    assign w_head = rec.rec_valid ? r_mem[r_rptr[AW-1:0]] : '0;
    assign {rec.rec_restart, rec.rec_partial, rec.rec_trunc,
            rec.rec_nack, rec.rec_nbytes, rec.rec_data} = w_head;

    assign bus_busy   = r_busy;
    assign shift_out  = r_shift;
    assign fifo_level = w_level;
    assign drop_cnt   = r_drop;
endmodule

// File: tb/tb_sccb_bus_monitor.sv
// ---------------------------------------------------------------------------
// tb_sccb_bus_monitor
// Drives SCCB transactions onto the pads and compares the records, FIFO
// level, drop count, bus_busy and raw shift register against a reference
// model built from the transaction description (bytes, ACK bits, trailing
// bits, closing condition).
// ---------------------------------------------------------------------------
module tb_sccb_bus_monitor;
    localparam int MB  = 4;
    localparam int FD  = 8;
    localparam int SW  = 32;
    localparam int GC  = 3;
    localparam int SS  = 2;
    localparam int NBW = $clog2(MB + 1);
    localparam int RW  = 8*MB + NBW + MB + 3;
    localparam int Q   = 8;   // clk cycles per bus phase, above filter latency

    localparam int O_NB  = 8*MB;
    localparam int O_NK  = O_NB + NBW;
    localparam int O_TR  = O_NK + MB;
    localparam int O_PA  = O_TR + 1;
    localparam int O_RS  = O_PA + 1;

    logic                       clk = 1'b0;
    logic                       rst, enable, scl_in, sda_in;
    logic                       bus_busy;
    logic [SW-1:0]              shift_out;
    logic [$clog2(FD+1)-1:0]    fifo_level;
    logic [15:0]                drop_cnt;

    sccb_bus_monitor_if #(.MAX_BYTES(MB)) rec_if ();

    sccb_bus_monitor #(
        .SYNC_STAGES(SS), .GLITCH_CYCLES(GC), .MAX_BYTES(MB),
        .FIFO_DEPTH(FD), .SHIFT_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .scl_in(scl_in), .sda_in(sda_in),
        .rec(rec_if),
        .bus_busy(bus_busy), .shift_out(shift_out),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [SW-1:0]  m_shift;
    logic           m_scl;
    logic [RW-1:0]  exp_q[$];
    int             m_drops;
    logic [7:0]     tx_bytes [16];
    logic           tx_acks  [16];
    int             tx_nb, tx_pb;
    logic [7:0]     tx_pbits;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
        $fatal(1);
    end

    // ---- bus drivers (also track the raw shift register model) ----
    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic set_scl(input logic v);
        if (v && !m_scl) m_shift = {m_shift[SW-2:0], sda_in};
        scl_in = v;
        m_scl  = v;
    endtask

    task automatic bus_start();
        sda_in = 1'b1; wq();
        set_scl(1'b1); wq();
        sda_in = 1'b0; wq();
        set_scl(1'b0); wq();
    endtask

    task automatic bus_stop();
        sda_in = 1'b0; wq();
        set_scl(1'b1); wq();
        sda_in = 1'b1; wq();
    endtask

    task automatic bus_bit(input logic b);
        sda_in = b; wq();
        set_scl(1'b1); wq();
        set_scl(1'b0); wq();
    endtask

    // One bit whose high phase contains an SCL low pulse of w clk cycles.
    task automatic bus_bit_glitch(input logic b, input int w);
        sda_in = b; wq();
        set_scl(1'b1); wq();
        scl_in = 1'b0;
        repeat (w) @(negedge clk);
        scl_in = 1'b1;
        if (w >= GC) m_shift = {m_shift[SW-2:0], sda_in};
        wq();
        set_scl(1'b0); wq();
    endtask

    task automatic send_txn();
        for (int i = 0; i < tx_nb; i++) begin
            for (int j = 7; j >= 0; j--) bus_bit(tx_bytes[i][j]);
            bus_bit(tx_acks[i]);
        end
        for (int j = 0; j < tx_pb; j++) bus_bit(tx_pbits[7-j]);
    endtask

    // Expected record of the current transaction description.
    function automatic logic [RW-1:0] model_rec(input logic restart);
        logic [8*MB-1:0] d;
        logic [MB-1:0]   nk;
        int              nb;
        d  = '0;
        nk = '0;
        nb = (tx_nb > MB) ? MB : tx_nb;
        for (int i = 0; i < nb; i++) begin
            d[8*i +: 8] = tx_bytes[i];
            nk[i]       = tx_acks[i];
        end
        return {restart, (tx_pb != 0), (tx_nb > MB), nk, NBW'(nb), d};
    endfunction

    function automatic void model_push(input logic [RW-1:0] r);
        if (tx_nb == 0 && tx_pb == 0) return;
        if (exp_q.size() < FD) exp_q.push_back(r);
        else                   m_drops++;
    endfunction

    function automatic void rand_txn(input int max_nb, input int max_pb);
        tx_nb    = $urandom_range(0, max_nb);
        tx_pb    = $urandom_range(0, max_pb);
        tx_pbits = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            tx_bytes[i] = 8'($urandom);
            tx_acks[i]  = 1'($urandom_range(0, 1));
        end
    endfunction

    task automatic pop_rec(output logic [RW-1:0] got, output bit ok);
        ok  = 1'b0;
        got = '0;
        for (int i = 0; i < 50; i++) begin
            if (rec_if.rec_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            got = {rec_if.rec_restart, rec_if.rec_partial, rec_if.rec_trunc,
                   rec_if.rec_nack, rec_if.rec_nbytes, rec_if.rec_data};
            rec_if.rec_ready = 1'b1;
            @(negedge clk);
            rec_if.rec_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_shift = '0;
        m_drops = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        do_reset();
        n_checks++; if (rec_if.rec_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", rec_if.rec_valid); else n_pass++;
        n_checks++; if (bus_busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus_busy); else n_pass++;
        n_checks++; if (shift_out !== '0) $display("FAIL reset_shift: got %h required 0", shift_out); else n_pass++;
        n_checks++; if (fifo_level !== '0) $display("FAIL reset_level: got %0d required 0", fifo_level); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0d required 0", drop_cnt); else n_pass++;
        n_checks++; if (rec_if.rec_data !== '0) $display("FAIL reset_data: got %h required 0", rec_if.rec_data); else n_pass++;
    endtask

    task automatic test_write();
        logic [RW-1:0] got, exp;
        bit ok;
        tx_nb = 3; tx_pb = 0;
        tx_bytes[0] = 8'h42; tx_bytes[1] = 8'h0A; tx_bytes[2] = 8'h5C;
        tx_acks[0] = 0; tx_acks[1] = 0; tx_acks[2] = 0;
        bus_start();
        n_checks++; if (bus_busy !== 1'b1) $display("FAIL write_busy_on: got %b required 1", bus_busy); else n_pass++;
        send_txn();
        bus_stop();
        exp = model_rec(1'b0);
        model_push(exp);
        n_checks++; if (bus_busy !== 1'b0) $display("FAIL write_busy_off: got %b required 0", bus_busy); else n_pass++;
        n_checks++; if (fifo_level !== 4'd1) $display("FAIL write_level: got %0d required 1", fifo_level); else n_pass++;
        n_checks++; if (shift_out !== m_shift) $display("FAIL write_shift: got %h required %h", shift_out, m_shift); else n_pass++;
        pop_rec(got, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) $display("FAIL write_rec: got %h (valid %0d) required %h", got, ok, exp); else n_pass++;
        n_checks++; if (got[23:0] !== 24'h5C0A42 || got[O_NK-1:O_NB] !== NBW'(3)) $display("FAIL write_bytes: got %h/%0d required 5c0a42/3", got[23:0], got[O_NK-1:O_NB]); else n_pass++;
    endtask

    task automatic test_restart();
        logic [RW-1:0] got, exp;
        bit ok;
        bus_start();
        tx_nb = 1; tx_pb = 0; tx_bytes[0] = 8'h43; tx_acks[0] = 0;
        send_txn();
        bus_start();
        model_push(model_rec(1'b1));
        n_checks++; if (bus_busy !== 1'b1) $display("FAIL restart_busy: got %b required 1", bus_busy); else n_pass++;
        tx_nb = 2; tx_bytes[1] = 8'h9D; tx_acks[1] = 1;
        send_txn();
        bus_stop();
        model_push(model_rec(1'b0));
        n_checks++; if (fifo_level !== 4'd2) $display("FAIL restart_level: got %0d required 2", fifo_level); else n_pass++;
        for (int r = 0; r < 2; r++) begin
            pop_rec(got, ok);
            exp = exp_q.pop_front();
            n_checks++; if (!ok || got !== exp) $display("FAIL restart_rec%0d: got %h (valid %0d) required %h", r, got, ok, exp); else n_pass++;
        end
        n_checks++; if (got[O_TR-1:O_NK] !== 4'b0010 || got[15:0] !== 16'h9D43) $display("FAIL restart_nack: got %b/%h required 0010/9d43", got[O_TR-1:O_NK], got[15:0]); else n_pass++;
    endtask

    task automatic test_trunc();
        logic [RW-1:0] got, exp;
        bit ok;
        tx_nb = 6; tx_pb = 0;
        for (int i = 0; i < 6; i++) begin
            tx_bytes[i] = 8'(i + 1);
            tx_acks[i]  = 1'b0;
        end
        bus_start();
        send_txn();
        bus_stop();
        model_push(model_rec(1'b0));
        pop_rec(got, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) $display("FAIL trunc_rec: got %h (valid %0d) required %h", got, ok, exp); else n_pass++;
        n_checks++; if (got[O_TR] !== 1'b1 || got[31:0] !== 32'h04030201) $display("FAIL trunc_flag: got %b/%h required 1/04030201", got[O_TR], got[31:0]); else n_pass++;
    endtask

    task automatic test_partial_and_empty();
        logic [RW-1:0] got, exp;
        bit ok;
        tx_nb = 0; tx_pb = 5; tx_pbits = 8'($urandom);
        bus_start();
        send_txn();
        bus_stop();
        model_push(model_rec(1'b0));
        pop_rec(got, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) $display("FAIL partial_rec: got %h (valid %0d) required %h", got, ok, exp); else n_pass++;
        n_checks++; if (got[O_PA] !== 1'b1) $display("FAIL partial_flag: got %b required 1", got[O_PA]); else n_pass++;
        // START immediately followed by STOP leaves nothing behind
        bus_start();
        bus_stop();
        wq();
        n_checks++; if (fifo_level !== 4'd0 || rec_if.rec_valid !== 1'b0) $display("FAIL empty_level: got %0d required 0", fifo_level); else n_pass++;
        n_checks++; if (drop_cnt !== 16'd0) $display("FAIL empty_drop: got %0d required 0", drop_cnt); else n_pass++;
    endtask

    task automatic test_glitch();
        logic [RW-1:0] got, exp;
        bit ok;
        logic [7:0] b;
        b = 8'hA5;
        bus_start();
        for (int j = 7; j >= 0; j--) begin
            if (j == 5) bus_bit_glitch(b[j], 2);
            else        bus_bit(b[j]);
        end
        bus_bit(1'b0);
        bus_stop();
        tx_nb = 1; tx_pb = 0; tx_bytes[0] = 8'hA5; tx_acks[0] = 0;
        model_push(model_rec(1'b0));
        // A 4-clk pulse during the first bit yields one extra 0 bit, so seven
        // driven bits plus the pulse form the byte 0x2D.
        bus_start();
        bus_bit_glitch(1'b0, 4);
        b = 8'h2D;
        for (int j = 5; j >= 0; j--) bus_bit(b[j]);
        bus_bit(1'b0);
        bus_stop();
        tx_bytes[0] = 8'h2D;
        model_push(model_rec(1'b0));
        n_checks++; if (shift_out !== m_shift) $display("FAIL glitch_shift: got %h required %h", shift_out, m_shift); else n_pass++;
        for (int r = 0; r < 2; r++) begin
            pop_rec(got, ok);
            exp = exp_q.pop_front();
            n_checks++; if (!ok || got !== exp) $display("FAIL glitch_rec%0d: got %h (valid %0d) required %h", r, got, ok, exp); else n_pass++;
        end
    endtask

    task automatic test_fifo_full();
        logic [RW-1:0] got, exp;
        bit ok;
        for (int t = 0; t < FD + 1; t++) begin
            rand_txn(1, 0);
            tx_nb = 1;
            bus_start();
            send_txn();
            bus_stop();
            model_push(model_rec(1'b0));
        end
        n_checks++; if (fifo_level !== 4'(FD)) $display("FAIL full_level: got %0d required %0d", fifo_level, FD); else n_pass++;
        n_checks++; if (drop_cnt !== 16'(m_drops) || drop_cnt !== 16'd1) $display("FAIL full_drop: got %0d required %0d", drop_cnt, m_drops); else n_pass++;
        for (int r = 0; r < FD; r++) begin
            pop_rec(got, ok);
            exp = exp_q.pop_front();
            n_checks++; if (!ok || got !== exp) $display("FAIL full_pop%0d: got %h (valid %0d) required %h", r, got, ok, exp); else n_pass++;
        end
        n_checks++; if (rec_if.rec_valid !== 1'b0) $display("FAIL full_drained: got %b required 0", rec_if.rec_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [RW-1:0] got, exp;
        bit ok;
        bit chained, rs;
        for (int round = 0; round < 2; round++) begin
            chained = 1'b0;
            for (int t = 0; t < 5; t++) begin
                if (!chained) bus_start();
                rand_txn(6, 7);
                send_txn();
                rs = (t < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (rs) bus_start();
                else    bus_stop();
                model_push(model_rec(rs));
                chained = rs;
            end
            n_checks++; if (fifo_level !== 4'(exp_q.size())) $display("FAIL rand_level: got %0d required %0d", fifo_level, exp_q.size()); else n_pass++;
            n_checks++; if (drop_cnt !== 16'(m_drops)) $display("FAIL rand_drop: got %0d required %0d", drop_cnt, m_drops); else n_pass++;
            n_checks++; if (shift_out !== m_shift) $display("FAIL rand_shift: got %h required %h", shift_out, m_shift); else n_pass++;
            while (exp_q.size() > 0) begin
                pop_rec(got, ok);
                exp = exp_q.pop_front();
                n_checks++; if (!ok || got !== exp) $display("FAIL rand_rec: got %h (valid %0d) required %h", got, ok, exp); else n_pass++;
            end
        end
    endtask

    task automatic test_enable();
        bus_start();
        for (int j = 7; j >= 4; j--) bus_bit(j[0]);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        for (int j = 3; j >= 0; j--) bus_bit(j[0]);
        bus_bit(1'b0);
        n_checks++; if (bus_busy !== 1'b0) $display("FAIL enable_busy: got %b required 0", bus_busy); else n_pass++;
        bus_stop();
        n_checks++; if (fifo_level !== 4'd0) $display("FAIL enable_discard: got %0d required 0", fifo_level); else n_pass++;
        n_checks++; if (shift_out !== m_shift) $display("FAIL enable_shift: got %h required %h", shift_out, m_shift); else n_pass++;
    endtask

    task automatic test_rst_mid();
        logic [RW-1:0] got, exp;
        bit ok;
        bus_start();
        for (int j = 0; j < 4; j++) bus_bit(1'($urandom_range(0, 1)));
        sda_in = 1'b1; wq();
        do_reset();
        n_checks++; if (bus_busy !== 1'b0 || shift_out !== '0) $display("FAIL rstmid_state: got busy %b shift %h required 0/0", bus_busy, shift_out); else n_pass++;
        wq();
        tx_nb = 1; tx_pb = 0; tx_bytes[0] = 8'($urandom); tx_acks[0] = 0;
        bus_start();
        send_txn();
        bus_stop();
        model_push(model_rec(1'b0));
        n_checks++; if (fifo_level !== 4'd1) $display("FAIL rstmid_level: got %0d required 1", fifo_level); else n_pass++;
        pop_rec(got, ok);
        exp = exp_q.pop_front();
        n_checks++; if (!ok || got !== exp) $display("FAIL rstmid_rec: got %h (valid %0d) required %h", got, ok, exp); else n_pass++;
        n_checks++; if (shift_out !== m_shift) $display("FAIL rstmid_shift: got %h required %h", shift_out, m_shift); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        scl_in = 1'b1;
        sda_in = 1'b1;
        m_scl = 1'b1;
        m_shift = '0;
        m_drops = 0;
        rec_if.rec_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_restart();
        test_trunc();
        test_partial_and_empty();
        test_glitch();
        test_fifo_full();
        test_random();
        test_enable();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
